// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the processor/memory bus: funct3 size codes, MMIO
// register offsets and the responder FSM encoding.
package mem_bus_responder_pkg;

    localparam logic [2:0] SizeB  = 3'd0;
    localparam logic [2:0] SizeH  = 3'd1;
    localparam logic [2:0] SizeW  = 3'd2;
    localparam logic [2:0] SizeBu = 3'd4;
    localparam logic [2:0] SizeHu = 3'd5;

    localparam logic [15:0] MmioLedOff = 16'h0000;
    localparam logic [15:0] MmioSwOff  = 16'h0004;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWaitRd = 2'd2,
        StResp   = 2'd3
    } state_t;

    // Size/alignment legality of a request; unsigned sizes cannot be stored.
    function automatic logic req_fmt_err(input logic we, input logic [2:0] size,
                                         input logic [1:0] lo);
        logic err;
        err = 1'b1;
        case (size)
            SizeB:   err = 1'b0;
            SizeBu:  err = we;
            SizeH:   err = lo[0];
            SizeHu:  err = we | lo[0];
            SizeW:   err = |lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Processor request/response channel plus the RAM port of the responder.
interface mem_bus_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic [13:0] ram_addr;
    logic [3:0]  ram_byteena;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output ram_addr, ram_byteena, ram_wren, ram_rden, ram_wdata
    );

    modport ram (
        input  ram_addr, ram_byteena, ram_wren, ram_rden, ram_wdata,
        output ram_q
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it
// according to the funct3 size code.
module load_align
    import mem_bus_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        data = word;
        case (size)
            SizeB:   data = {{24{shifted[7]}}, shifted[7:0]};
            SizeBu:  data = {24'b0, shifted[7:0]};
            SizeH:   data = {{16{shifted[15]}}, shifted[15:0]};
            SizeHu:  data = {16'b0, shifted[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: routes processor loads/stores to a
// synchronous RAM or to the LED/switch MMIO registers, one response per request.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] MMIO_BASE    = 16'hF000
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_bus_responder_if.slave        bus,
    output logic [9:0]                led_out,
    input  logic [9:0]                sw_in
);

    localparam logic [15:0] LedAddr = MMIO_BASE + MmioLedOff;
    localparam logic [15:0] SwAddr  = MMIO_BASE + MmioSwOff;
    localparam logic [1:0]  CntInit = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        hold_q, hold_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [9:0]  led_q, led_d;

    logic        accept, mmio_bad, req_err, is_ram, ram_access, rsp_valid;
    logic [3:0]  store_be;
    logic [31:0] store_data, align_data;

    assign accept   = bus.req_valid && (state_q == StIdle);
    // Switches are read-only; everything in the window besides the two registers is unmapped.
    assign mmio_bad = (bus.req_addr >= MMIO_BASE) &&
                      !((bus.req_addr == LedAddr) || (!bus.req_we && bus.req_addr == SwAddr));
    assign req_err  = req_fmt_err(bus.req_we, bus.req_size, bus.req_addr[1:0]) || mmio_bad;
    assign is_ram     = addr_q < MMIO_BASE;
    assign ram_access = (state_q == StAccess) && is_ram;

    load_align u_load_align (
        .word   (bus.ram_q),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .data   (align_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
            end
        end
    end

    // Errors spend two cycles in StResp so their response lands where a store's would.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_err ? StResp : StAccess;
                    hold_d  = req_err;
                end
            end
            StAccess: begin
                if (we_q) begin
                    rdata_d = '0;
                    if (!is_ram) led_d = wdata_q[9:0];
                    state_d = StResp;
                end else if (is_ram) begin
                    cnt_d   = CntInit;
                    state_d = StWaitRd;
                end else begin
                    rdata_d = (addr_q == SwAddr) ? {22'b0, sw_in} : {22'b0, led_q};
                    state_d = StResp;
                end
            end
            StWaitRd: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = align_data;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                if (hold_q) begin
                    hold_d  = 1'b0;
                    rdata_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        store_be   = 4'b1111;
        store_data = wdata_q;
        case (size_q)
            SizeB: begin
                store_be   = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            SizeH: begin
                store_be   = 4'b0011 << addr_q[1:0];
                store_data = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign rsp_valid       = (state_q == StResp) && !hold_q;
    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_err     = rsp_valid && err_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.ram_addr    = addr_q[15:2];
    assign bus.ram_wren    = ram_access && we_q;
    assign bus.ram_rden    = ram_access && !we_q;
    assign bus.ram_byteena = ram_access ? (we_q ? store_be : 4'b1111) : 4'b0000;
    assign bus.ram_wdata   = (ram_access && we_q) ? store_data : 32'h0;
    assign led_out         = led_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with a behavioural pipelined RAM.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    localparam int unsigned RL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] led_out;
    logic [9:0] sw_in;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_bus_responder_if bus ();

    mem_bus_responder #(
        .READ_LATENCY (RL),
        .MMIO_BASE    (16'hF000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .led_out (led_out),
        .sw_in   (sw_in)
    );

    // RAM: data for a read strobe in cycle n appears on ram_q in cycle n+RL
    logic [31:0] mem [0:63];
    logic [31:0] rd_pipe [0:RL-1];

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            for (int i = 0; i < 4; i++)
                if (bus.ram_byteena[i])
                    mem[bus.ram_addr[5:0]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
        end
        if (bus.ram_rden) rd_pipe[0] <= mem[bus.ram_addr[5:0]];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_q = rd_pipe[RL-1];

    int          o_rsp, o_wr, o_rd, o_strobes;
    logic        o_err, o_both, o_after_valid, o_after_ready;
    logic [31:0] o_rdata, o_wd;
    logic [3:0]  o_be;

    // Issues one request (accepted at the end of cycle T) and records what happens in T+k.
    task automatic run_req(input logic we, input logic [15:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        o_rsp = -1; o_wr = -1; o_rd = -1; o_strobes = 0;
        o_err = 1'b0; o_both = 1'b0; o_rdata = '0; o_wd = '0; o_be = '0;
        for (int k = 1; k <= 10 && o_rsp < 0; k++) begin
            @(negedge clk);
            if (bus.ram_wren && bus.ram_rden) o_both = 1'b1;
            if (bus.ram_wren) begin
                o_strobes++; o_wr = k; o_be = bus.ram_byteena; o_wd = bus.ram_wdata;
            end
            if (bus.ram_rden) begin
                o_strobes++; o_rd = k; o_be = bus.ram_byteena;
            end
            if (bus.rsp_valid) begin
                o_rsp = k; o_err = bus.rsp_err; o_rdata = bus.rsp_rdata;
            end
        end
        @(negedge clk);
        o_after_valid = bus.rsp_valid;
        o_after_ready = bus.req_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.ram_wren, bus.ram_rden} !== 4'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {bus.rsp_valid, bus.rsp_err, bus.ram_wren, bus.ram_rden});
        end
        checks++;
        if ({bus.rsp_rdata, bus.ram_wdata, bus.ram_addr, bus.ram_byteena, led_out} !== '0) begin
            fails++;
            $display("FAIL reset_data: rdata %h wdata %h addr %h be %b led %h want all 0",
                     bus.rsp_rdata, bus.ram_wdata, bus.ram_addr, bus.ram_byteena, led_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_word();
        run_req(1'b1, 16'h0010, SizeW, 32'hDEADBEEF);
        checks++;
        if ({o_wr, o_be, o_wd, o_strobes} !== {32'sd1, 4'b1111, 32'hDEADBEEF, 32'sd1}) begin
            fails++; $display("FAIL sw_ram: wr_cyc %0d be %b wdata %h strobes %0d want 1 1111 deadbeef 1",
                              o_wr, o_be, o_wd, o_strobes);
        end
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {32'sd2, 1'b0, 32'h0}) begin
            fails++; $display("FAIL sw_rsp: cyc %0d err %b rdata %h want 2 0 0", o_rsp, o_err, o_rdata);
        end
        run_req(1'b0, 16'h0010, SizeW, 32'h0);
        checks++;
        if ({o_rd, o_be, o_strobes} !== {32'sd1, 4'b1111, 32'sd1}) begin
            fails++; $display("FAIL lw_rden: rd_cyc %0d be %b strobes %0d want 1 1111 1",
                              o_rd, o_be, o_strobes);
        end
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {32'sd4, 1'b0, 32'hDEADBEEF}) begin
            fails++; $display("FAIL lw_rsp: cyc %0d err %b rdata %h want 4 0 deadbeef",
                              o_rsp, o_err, o_rdata);
        end
        checks++;
        if ({o_after_valid, o_after_ready} !== 2'b01) begin
            fails++; $display("FAIL lw_pulse: next valid %b ready %b want 0 1",
                              o_after_valid, o_after_ready);
        end
    endtask

    task automatic test_sub_word();
        logic [15:0] addrs [4] = '{16'h0013, 16'h0013, 16'h0012, 16'h0010};
        logic [2:0]  sizes [4] = '{SizeB, SizeBu, SizeHu, SizeH};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD, 32'hFFFFBEEF};
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, addrs[i], sizes[i], 32'h0);
            checks++;
            if ({o_rsp, o_err, o_rdata} !== {32'sd4, 1'b0, exps[i]}) begin
                fails++; $display("FAIL subword_%0d: cyc %0d err %b rdata %h want 4 0 %h",
                                  i, o_rsp, o_err, o_rdata, exps[i]);
            end
        end
    endtask

    task automatic test_half_store();
        run_req(1'b1, 16'h0020, SizeW, 32'hCAFEF00D);
        run_req(1'b1, 16'h0022, SizeH, 32'h00001234);
        checks++;
        if ({o_be, o_wd} !== {4'b1100, 32'h12341234}) begin
            fails++; $display("FAIL sh_lanes: be %b wdata %h want 1100 12341234", o_be, o_wd);
        end
        run_req(1'b0, 16'h0020, SizeW, 32'h0);
        checks++;
        if (o_rdata !== 32'h1234F00D) begin
            fails++; $display("FAIL sh_readback: got %h want 1234f00d", o_rdata);
        end
        run_req(1'b1, 16'h0001, SizeB, 32'h000000A5);
        checks++;
        if ({o_be, o_wd, o_rdata} !== {4'b0010, 32'hA5A5A5A5, 32'h0}) begin
            fails++; $display("FAIL sb_lanes: be %b wdata %h rdata %h want 0010 a5a5a5a5 0",
                              o_be, o_wd, o_rdata);
        end
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] addrs [4] = '{16'h0002, 16'h0001, 16'h0000, 16'h0000};
        logic [2:0]  sizes [4] = '{SizeW, SizeH, 3'd3, SizeBu};
        run_req(1'b1, 16'h0000, SizeW, 32'h11223344);
        run_req(1'b0, 16'h0000, SizeW, 32'h0);
        for (int i = 0; i < 4; i++) begin
            run_req(wes[i], addrs[i], sizes[i], 32'hFFFFFFFF);
            checks++;
            if ({o_rsp, o_err, o_rdata, o_strobes} !== {32'sd2, 1'b1, 32'h0, 32'sd0}) begin
                fails++; $display("FAIL err_%0d: cyc %0d err %b rdata %h strobes %0d want 2 1 0 0",
                                  i, o_rsp, o_err, o_rdata, o_strobes);
            end
        end
        run_req(1'b0, 16'h0000, SizeW, 32'h0);
        checks++;
        if ({o_err, o_rdata} !== {1'b0, 32'h11223344}) begin
            fails++; $display("FAIL err_mem_intact: err %b rdata %h want 0 11223344", o_err, o_rdata);
        end
    endtask

    task automatic test_mmio();
        run_req(1'b1, 16'hF000, SizeW, 32'h000003FF);
        checks++;
        if ({led_out, o_rsp, o_err, o_strobes} !== {10'h3FF, 32'sd2, 1'b0, 32'sd0}) begin
            fails++; $display("FAIL led_store: led %h cyc %0d err %b strobes %0d want 3ff 2 0 0",
                              led_out, o_rsp, o_err, o_strobes);
        end
        sw_in = 10'h155;
        run_req(1'b0, 16'hF004, SizeW, 32'h0);
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {32'sd2, 1'b0, 32'h00000155}) begin
            fails++; $display("FAIL sw_load: cyc %0d err %b rdata %h want 2 0 00000155",
                              o_rsp, o_err, o_rdata);
        end
        run_req(1'b0, 16'hF008, SizeW, 32'h0);
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {32'sd2, 1'b1, 32'h0}) begin
            fails++; $display("FAIL mmio_unmapped: cyc %0d err %b rdata %h want 2 1 0",
                              o_rsp, o_err, o_rdata);
        end
        run_req(1'b1, 16'hF000, SizeB, 32'h000002AB);
        run_req(1'b0, 16'hF000, SizeW, 32'h0);
        checks++;
        if ({led_out, o_rdata} !== {10'h2AB, 32'h000002AB}) begin
            fails++; $display("FAIL led_readback: led %h rdata %h want 2ab 000002ab", led_out, o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int late = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_size  = SizeW;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wren, bus.ram_rden} !== 5'b10000) begin
            fails++; $display("FAIL midrst_ctrl: ready/valid/err/wren/rden %b want 10000",
                              {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wren, bus.ram_rden});
        end
        checks++;
        if ({bus.rsp_rdata, bus.ram_wdata, bus.ram_addr, bus.ram_byteena, led_out} !== '0) begin
            fails++; $display("FAIL midrst_data: rdata %h wdata %h addr %h be %b led %h want all 0",
                              bus.rsp_rdata, bus.ram_wdata, bus.ram_addr, bus.ram_byteena, led_out);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.ram_wren || bus.ram_rden) late++;
        end
        checks++;
        if (late !== 0) begin
            fails++; $display("FAIL midrst_quiet: %0d active cycles want 0", late);
        end
        rst = 1'b1;
        run_req(1'b0, 16'h0010, SizeW, 32'h0);
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {32'sd4, 1'b0, 32'hDEADBEEF}) begin
            fails++; $display("FAIL midrst_recover: cyc %0d err %b rdata %h want 4 0 deadbeef",
                              o_rsp, o_err, o_rdata);
        end
    endtask

    // Strobe exclusivity is watched over the whole run.
    int both_seen = 0;
    always @(negedge clk) if (bus.ram_wren && bus.ram_rden) both_seen++;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        sw_in         = '0;
        test_reset();
        test_word();
        test_sub_word();
        test_half_store();
        test_errors();
        test_mmio();
        test_reset_mid();
        checks++;
        if (both_seen !== 0) begin
            fails++; $display("FAIL strobe_exclusive: %0d overlap cycles want 0", both_seen);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
